// File: rtl/serial_pkg.sv
// serial_pkg: shared UART types and constants for serial_tx and serial_rx
package serial_pkg;
  localparam int DEFAULT_CLKS_PER_BIT = 868;
  localparam int DATA_BITS = 8;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
endpackage

// File: rtl/baud_counter.sv
// baud_counter: free-running 0..CLKS_PER_BIT-1 counter; tick_out marks the last clock of each bit period; clear_in holds it at 0
module baud_counter #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_in,
  output logic tick_out
);
  localparam int W = $clog2(CLKS_PER_BIT);
  logic [W-1:0] r_cnt;
  assign tick_out = r_cnt == W'(CLKS_PER_BIT - 1);
  always_ff @(posedge clk_in)
    r_cnt <= (rst_in || clear_in || tick_out) ? '0 : r_cnt + W'(1);
endmodule

// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter (clk_in/rst_in, data_in+valid_in/ready_out handshake, idle-high data_out line, busy_out); define SERIAL_TX_PARITY_EN for an even parity bit (8E1)
module serial_tx
  import serial_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic [7:0] data_in,
  input  logic       valid_in,
  output logic       ready_out,
  output logic       data_out,
  output logic       busy_out
);
  tx_state_t  r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit;
  logic       r_data_out;
  logic       r_ready;
`ifdef SERIAL_TX_PARITY_EN
  logic       r_parity;
`endif
  logic       w_tick;
  logic       w_clear;
  assign w_clear   = r_state == IDLE;
  assign ready_out = r_ready;
  assign busy_out  = ~r_ready;
  assign data_out  = r_data_out;
  baud_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_baud (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_in (w_clear),
    .tick_out (w_tick)
  );
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state    <= IDLE;
      r_shift    <= '0;
      r_bit      <= '0;
      r_data_out <= 1'b1;
      r_ready    <= 1'b1;
`ifdef SERIAL_TX_PARITY_EN
      r_parity   <= 1'b0;
`endif
    end else begin
      case (r_state)
        IDLE: if (valid_in) begin
          r_state    <= START;
          r_shift    <= data_in;
          r_bit      <= '0;
          r_data_out <= 1'b0;
          r_ready    <= 1'b0;
`ifdef SERIAL_TX_PARITY_EN
          r_parity   <= ^data_in;
`endif
        end
        START: if (w_tick) begin
          r_state    <= DATA;
          r_data_out <= r_shift[0];
        end
        DATA: if (w_tick) begin
          if (r_bit == 3'(DATA_BITS - 1)) begin
`ifdef SERIAL_TX_PARITY_EN
            r_state    <= PARITY;
            r_data_out <= r_parity;
`else
            r_state    <= STOP;
            r_data_out <= 1'b1;
`endif
          end else begin
            // output is registered, so drive the bit that becomes shift[0] after this shift
            r_shift    <= {1'b0, r_shift[7:1]};
            r_bit      <= r_bit + 3'd1;
            r_data_out <= r_shift[1];
          end
        end
`ifdef SERIAL_TX_PARITY_EN
        PARITY: if (w_tick) begin
          r_state    <= STOP;
          r_data_out <= 1'b1;
        end
`endif
        STOP: if (w_tick) begin
          r_state <= IDLE;
          r_ready <= 1'b1;
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: self-checking bench for serial_tx with a receiver model feeding a byte scoreboard
module tb_serial_tx;
  localparam int CPB = 4;
`ifdef SERIAL_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif

  logic       clk = 1'b0;
  logic       rst_in = 1'b1;
  logic [7:0] data_in = 8'h81;
  logic       valid_in = 1'b1;
  logic       ready_out;
  logic       data_out;
  logic       busy_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [7:0] q[$];

  logic       rx_on = 1'b0;
  int         rx_n = 0;
  logic [7:0] rx_byte;
  logic       rx_par;
  logic [7:0] rx_exp;

  serial_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk_in    (clk),
    .rst_in    (rst_in),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .ready_out (ready_out),
    .data_out  (data_out),
    .busy_out  (busy_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_in) rx_on = 1'b0;
    else if (!rx_on) begin
      if (data_out === 1'b0) begin
        rx_on = 1'b1;
        rx_n = 0;
      end
    end else rx_n++;
    if (rx_on && rx_n % CPB == CPB / 2) begin
      if (rx_n / CPB == 0) begin
        total++;
        if (data_out !== 1'b0) begin
          bad++;
          $display("FAIL rx_start: line=%b want=0", data_out);
        end
      end else if (rx_n / CPB <= 8) rx_byte[rx_n / CPB - 1] = data_out;
      else if (rx_n / CPB == NB - 1) begin
        rx_on = 1'b0;
        total++;
        if (data_out !== 1'b1) begin
          bad++;
          $display("FAIL rx_stop: line=%b want=1", data_out);
        end
        total++;
        if (q.size() == 0) begin
          bad++;
          $display("FAIL rx_unexpected: got=%h want=none", rx_byte);
        end else begin
          rx_exp = q.pop_front();
          if (rx_byte !== rx_exp) begin
            bad++;
            $display("FAIL rx_byte: got=%h want=%h", rx_byte, rx_exp);
          end
`ifdef SERIAL_TX_PARITY_EN
          total++;
          if (rx_par !== ^rx_exp) begin
            bad++;
            $display("FAIL rx_parity: got=%b want=%b", rx_par, ^rx_exp);
          end
`endif
        end
      end else rx_par = data_out;
    end
  end

  function automatic logic exp_bit(input logic [7:0] b, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return b[p-1];
`ifdef SERIAL_TX_PARITY_EN
    if (p == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] b, input bit push, output int hs);
    data_in = b;
    valid_in = 1'b1;
    for (int i = 0; i < 200 && ready_out !== 1'b1; i++) @(negedge clk);
    total++;
    if (ready_out !== 1'b1) begin
      bad++;
      $display("FAIL send_timeout: ready=%b want=1", ready_out);
    end
    hs = cyc + 1;
    if (push) q.push_back(b);
    @(negedge clk);
  endtask

  task automatic send_and_check(input logic [7:0] b, input string name);
    int hs;
    int errs;
    send(b, 1'b1, hs);
    valid_in = 1'b0;
    errs = 0;
    for (int k = 0; k < NB * CPB; k++) begin
      if (data_out !== exp_bit(b, k / CPB) || ready_out !== 1'b0 || busy_out !== 1'b1) begin
        errs++;
        if (errs < 4)
          $display("FAIL %s_wave: clk=%0d line=%b ready=%b busy=%b want line=%b ready=0 busy=1",
                   name, k, data_out, ready_out, busy_out, exp_bit(b, k / CPB));
      end
      data_in = ~data_in;
      @(negedge clk);
    end
    total++;
    if (errs != 0) bad++;
    total++;
    if (ready_out !== 1'b1 || busy_out !== 1'b0 || data_out !== 1'b1) begin
      bad++;
      $display("FAIL %s_end: ready=%b busy=%b line=%b want 1 0 1 at clk %0d",
               name, ready_out, busy_out, data_out, NB * CPB);
    end
  endtask

  task automatic wait_drain(input string name);
    for (int i = 0; i < 200 && (q.size() != 0 || rx_on); i++) @(negedge clk);
    total++;
    if (q.size() != 0 || rx_on) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d want=0", name, q.size());
    end
  endtask

  task automatic test_reset();
    repeat (3) begin
      @(negedge clk);
      total++;
      if (data_out !== 1'b1) begin
        bad++;
        $display("FAIL reset_line: got=%b want=1", data_out);
      end
    end
    total++;
    if (ready_out !== 1'b1 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL reset_flags: ready=%b busy=%b want 1 0", ready_out, busy_out);
    end
    rst_in = 1'b0;
    valid_in = 1'b0;
    repeat (2) @(negedge clk);
    total++;
    if (data_out !== 1'b1 || ready_out !== 1'b1) begin
      bad++;
      $display("FAIL reset_nostart: line=%b ready=%b want 1 1", data_out, ready_out);
    end
  endtask

  task automatic test_single();
    send_and_check(8'h55, "single55");
    wait_drain("single55");
  endtask

  task automatic test_back_to_back();
    int hs1;
    int hs2;
    send(8'hA5, 1'b1, hs1);
    send(8'h3C, 1'b1, hs2);
    total++;
    if (hs2 - (hs1 + (NB - 1) * CPB) != CPB + 1) begin
      bad++;
      $display("FAIL b2b_gap: stop_to_start=%0d want=%0d", hs2 - (hs1 + (NB - 1) * CPB), CPB + 1);
    end
    valid_in = 1'b0;
    repeat (7) @(negedge clk);
    data_in = 8'hFF;
    repeat (9) @(negedge clk);
    data_in = 8'h00;
    wait_drain("b2b");
  endtask

  task automatic test_reset_mid();
    int hs;
    send(8'hFF, 1'b0, hs);
    valid_in = 1'b0;
    for (int i = 0; i < 100 && cyc < hs + 4 * CPB + 1; i++) @(negedge clk);
    rst_in = 1'b1;
    @(negedge clk);
    total++;
    if (data_out !== 1'b1 || ready_out !== 1'b1 || busy_out !== 1'b0) begin
      bad++;
      $display("FAIL midreset: line=%b ready=%b busy=%b want 1 1 0", data_out, ready_out, busy_out);
    end
    @(negedge clk);
    rst_in = 1'b0;
    @(negedge clk);
    send_and_check(8'h00, "after_reset");
    wait_drain("after_reset");
  endtask

`ifdef SERIAL_TX_PARITY_EN
  task automatic test_parity();
    send_and_check(8'h07, "parity07");
    send_and_check(8'h03, "parity03");
    wait_drain("parity");
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_reset_mid();
`ifdef SERIAL_TX_PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
